// File: rtl/baud_generator.sv
// baud_generator: programmable UART oversampling tick generator.
// Produces a one-cycle `tick` strobe every DIV clock cycles, where DIV is the
// rounded ratio CLK_FREQ / (OVERSAMPLE * baud) for the baud rate chosen by the
// 4-bit `baud_rate_sel` code. A change of code restarts the period from zero.
module baud_generator #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud_rate_sel,
  output logic       tick
);

  // Rounded divisor for a given baud rate, evaluated only on constants so no
  // divider hardware is ever built.
  function automatic int div_of(input int baud);
    return (CLK_FREQ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

  // Terminal counts (DIV-1) for each supported rate.
  localparam logic [CNT_W-1:0] DIVM1_1200   = CNT_W'(div_of(1200)   - 1);
  localparam logic [CNT_W-1:0] DIVM1_2400   = CNT_W'(div_of(2400)   - 1);
  localparam logic [CNT_W-1:0] DIVM1_4800   = CNT_W'(div_of(4800)   - 1);
  localparam logic [CNT_W-1:0] DIVM1_9600   = CNT_W'(div_of(9600)   - 1);
  localparam logic [CNT_W-1:0] DIVM1_19200  = CNT_W'(div_of(19200)  - 1);
  localparam logic [CNT_W-1:0] DIVM1_38400  = CNT_W'(div_of(38400)  - 1);
  localparam logic [CNT_W-1:0] DIVM1_57600  = CNT_W'(div_of(57600)  - 1);
  localparam logic [CNT_W-1:0] DIVM1_115200 = CNT_W'(div_of(115200) - 1);
  localparam logic [CNT_W-1:0] DIVM1_230400 = CNT_W'(div_of(230400) - 1);
  localparam logic [CNT_W-1:0] DIVM1_460800 = CNT_W'(div_of(460800) - 1);
  localparam logic [CNT_W-1:0] DIVM1_921600 = CNT_W'(div_of(921600) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [3:0]       sel_q, sel_d;
  logic [CNT_W-1:0] div_m1;
  logic             sel_changed;

  // Decode the select code into the terminal count; unused codes fall back
  // to 9600 baud.
  always_comb begin
    case (baud_rate_sel)
      4'd0:    div_m1 = DIVM1_1200;
      4'd1:    div_m1 = DIVM1_2400;
      4'd2:    div_m1 = DIVM1_4800;
      4'd3:    div_m1 = DIVM1_9600;
      4'd4:    div_m1 = DIVM1_19200;
      4'd5:    div_m1 = DIVM1_38400;
      4'd6:    div_m1 = DIVM1_57600;
      4'd7:    div_m1 = DIVM1_115200;
      4'd8:    div_m1 = DIVM1_230400;
      4'd9:    div_m1 = DIVM1_460800;
      4'd10:   div_m1 = DIVM1_921600;
      default: div_m1 = DIVM1_9600;
    endcase
  end

  // Next-state: restart on a rate change, otherwise count to DIV-1 and strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    sel_d       = sel_q;
    sel_changed = (baud_rate_sel != sel_q);
    if (sel_changed) begin
      cnt_d = '0;
      sel_d = baud_rate_sel;
    end else if (cnt_q >= div_m1) begin
      // >= rather than == so the counter can never run past the terminal
      // count and wrap through 2^CNT_W.
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; the select is captured during
  // reset so the first period after release uses the selected rate directly.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // values, independent of statement order.
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sel_q  <= baud_rate_sel;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sel_q  <= sel_d;
    end
  end

  assign tick = tick_q;

  // While the selection is stable the counter stays within the period.
  a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
    (baud_rate_sel == sel_q) |-> (cnt_q <= div_m1));

endmodule

// File: tb/tb_baud_generator.sv
// Scoreboard bench for baud_generator: the driver predicts, per stimulus
// segment, the clock edges after which `tick` must be high and queues them;
// an independent monitor checks every observed tick against that queue.
module tb_baud_generator;

  logic       clk;
  logic       reset;
  logic [3:0] baud_rate_sel;
  logic       tick;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;          // number of rising edges so far
  bit done = 1'b0;
  int exp_q[$];            // edge numbers after which a tick is expected

  // Reference model state: current registered selection and the edge the
  // present period train is anchored to.
  logic [3:0] cur_sel;
  int         origin;

  // Divisors taken straight from the rate table (default parameters).
  int div_tbl[16] = '{5208, 2604, 1302, 651, 326, 163, 109, 54, 27, 14, 7,
                      651, 651, 651, 651, 651};

  baud_generator dut (
    .clk           (clk),
    .reset         (reset),
    .baud_rate_sel (baud_rate_sel),
    .tick          (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0] < edge_n) begin
        tests++;
        fails++;
        $display("FAIL missing_tick: expected tick after edge %0d, no tick observed (now edge %0d)",
                 exp_q[0], edge_n);
        void'(exp_q.pop_front());
      end
      if ($isunknown(tick)) begin
        tests++;
        fails++;
        $display("FAIL tick_x: tick=%b after edge %0d, required 0 or 1", tick, edge_n);
      end else if (tick) begin
        tests++;
        if (exp_q.size() > 0 && exp_q[0] == edge_n) begin
          void'(exp_q.pop_front());
        end else begin
          fails++;
          $display("FAIL unexpected_tick: tick=1 after edge %0d, next expected edge %0d",
                   edge_n, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
      end
    end
  end

  // Drive one segment of constant inputs for n cycles and queue the ticks the
  // rate rules predict inside it.
  task automatic run_seg(input bit rst, input logic [3:0] s, input int n);
    int k;
    int d;
    int j;
    k = edge_n;
    if (rst) begin
      cur_sel = s;
      origin  = k + n;
    end else begin
      if (s != cur_sel) begin
        cur_sel = s;
        origin  = k + 1;
      end
      d = div_tbl[s];
      j = (k + 1 - origin + d - 1) / d;
      if (j < 1) j = 1;
      for (int t = origin + j * d; t <= k + n; t += d) exp_q.push_back(t);
    end
    reset         = rst;
    baud_rate_sel = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    baud_rate_sel = 4'd8;
    cur_sel       = 4'd8;
    origin        = 0;

    // Reset 5 cycles, then sel 8: first tick 27 after release, 185 ticks.
    run_seg(1'b1, 4'd8, 5);
    run_seg(1'b0, 4'd8, 5000);

    // Slowest rate, then a change to 2400 baud.
    run_seg(1'b0, 4'd0, 30000);
    run_seg(1'b0, 4'd1, 8000);

    // Sweep every code, including two invalid ones.
    for (int s = 0; s <= 10; s++) run_seg(1'b0, 4'(s), 2 * div_tbl[s] + 3);
    run_seg(1'b0, 4'd12, 2 * 651 + 3);
    run_seg(1'b0, 4'd15, 2 * 651 + 3);

    // Change 7 -> 3 registered exactly on the edge a tick would fire.
    run_seg(1'b0, 4'd7, 54 * 5);
    run_seg(1'b0, 4'd3, 2000);

    // One-cycle reset in the middle of a sel 6 period.
    run_seg(1'b0, 4'd6, 300);
    run_seg(1'b1, 4'd6, 1);
    run_seg(1'b0, 4'd6, 250);

    // Undriven select during reset, valid code on the final reset cycle.
    run_seg(1'b1, 4'bxxxx, 4);
    run_seg(1'b1, 4'd10, 1);
    run_seg(1'b0, 4'd10, 100);

    // Randomized segments: rate changes, repeats of the same code, resets.
    for (int i = 0; i < 40; i++) begin
      bit         r;
      logic [3:0] s;
      r = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) == 0) ? cur_sel : 4'($urandom_range(0, 15));
      run_seg(r, s, r ? $urandom_range(1, 3) : $urandom_range(1, 600));
    end

    // Let the monitor see the last edge, then close the scoreboard.
    @(negedge clk);
    #1 done = 1'b1;
    while (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL missing_tick: expected tick after edge %0d, no tick observed by end", exp_q[0]);
      void'(exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/baud_generator.md
# baud_generator

Programmable baud-rate tick generator for the UART. From the system clock it produces a single-cycle `tick` strobe at 16× the selected baud rate. The UART transmitter and receiver use it as their oversampling/bit-timing enable. The rate is selected at run time through a 4-bit code.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz; used only to derive divisors at elaboration.
- `OVERSAMPLE`, default 16: ticks per baud bit.
- `CNT_W`, default 16: divisor counter width. It must hold the largest divisor; the default 5208 fits.
- `clk`, input, 1: system clock. All logic is on the rising edge; this is the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `baud_rate_sel`, input, 4: baud-rate select code. It is treated as quasi-static but may change at any cycle.
- `tick`, output, 1: registered strobe, high for exactly one `clk` cycle per tick period.

## Operation
- Divisor: DIV = round(CLK_FREQ / (OVERSAMPLE × baud)), computed at elaboration as (CLK_FREQ + OVERSAMPLE×baud/2) / (OVERSAMPLE×baud) in integer arithmetic.
- Select map with default-parameter DIV values:
  - 0 → 1200 baud, DIV 5208
  - 1 → 2400 baud, DIV 2604
  - 2 → 4800 baud, DIV 1302
  - 3 → 9600 baud, DIV 651
  - 4 → 19200 baud, DIV 326
  - 5 → 38400 baud, DIV 163
  - 6 → 57600 baud, DIV 109
  - 7 → 115200 baud, DIV 54
  - 8 → 230400 baud, DIV 27
  - 9 → 460800 baud, DIV 14
  - 10 → 921600 baud, DIV 7
  - 11–15 → invalid; they use the 9600-baud divisor (651).
- Divisor lookup is a combinational decode of `baud_rate_sel`.
- Counter `cnt` (CNT_W bits) behaviour on every rising edge:
  - if `reset`: `cnt` ← 0, `tick` ← 0, `sel_q` ← `baud_rate_sel`;
  - else if `baud_rate_sel` ≠ `sel_q`: `cnt` ← 0, `tick` ← 0, `sel_q` ← `baud_rate_sel` (restart on rate change);
  - else if `cnt` = DIV−1: `cnt` ← 0, `tick` ← 1;
  - else: `cnt` ← `cnt`+1, `tick` ← 0.
- No free-running state persists across a rate change. The first tick at a new rate therefore comes one full DIV period after the change is registered.
- `cnt` never exceeds DIV−1 of the current selection and never wraps through 2^CNT_W.
- `baud_rate_sel` may be X/undriven while `reset` is high; reset dominates and no X reaches `tick`.

## Timing
- Reset values: `tick` = 0 and `cnt` = 0. Both take effect on the first rising edge with `reset` high.
- Let edge 0 be the last edge with `reset` high.
- `tick` rises after edge DIV and stays high for one cycle, until edge DIV+1.
- Tick period is exactly DIV cycles; duty is 1 cycle high and DIV−1 cycles low.
- Example: sel 8 at 100 MHz gives a tick every 27 cycles (270 ns), i.e. ≈3.704 MHz, which is 16 × 231481 baud (+0.47 %).
- Rate change registered at edge E: `tick` is 0 after E. The next tick rises after edge E+DIV_new, including when the change coincides with a tick cycle.
- Reset asserted mid-count: `tick` and `cnt` clear on that edge; counting resumes from 0 after release.
- `tick` has no combinational path from any input.

## Test plan
- Reset held 5 cycles, then sel 8 for 5000 cycles:
  - `tick` = 0 during reset;
  - first tick 27 cycles after release;
  - then exactly 185 ticks, each 1 cycle wide, spaced 27 cycles apart.
- sel 0 for 30000 cycles → ticks every 5208 cycles (5 ticks). Then sel 1 → first tick 2604 cycles after the change, and steady 2604-cycle spacing.
- Sweep sel 0–10, measuring tick spacing for each → matches the DIV table exactly. sel 12 and sel 15 → spacing 651.
- Change sel 7→3 on the same cycle `tick` would fire → no tick on that cycle; next tick 651 cycles later, with no short or double pulse.
- Assert `reset` for 1 cycle mid-period at sel 6 → `tick` = 0 next cycle; next tick 109 cycles after the release edge.
- sel X during reset, then valid sel 10 → `tick` never X; tick every 7 cycles.
